// File: rtl/spi_frame_sched.sv
// Frame scheduler feeding an SPI slave: sync header, sequence/channel header,
// DATA_NUM payload bytes from one of two channel FIFOs, and a drain on abort.
module spi_frame_sched #(
    parameter int         POINT_NUM = 400,
    parameter int         DATA_NUM  = POINT_NUM * 2,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       spi_cs,
    input  logic       byte_req,
    output logic [7:0] spi_data,
    input  logic       ch0_frame_rdy,
    input  logic       ch1_frame_rdy,
    input  logic [7:0] ch0_dout,
    input  logic [7:0] ch1_dout,
    output logic       ch0_rd_en,
    output logic       ch1_rd_en,
    output logic       frame_busy,
    output logic [1:0] frame_ch,
    output logic       frame_done,
    output logic       frame_abort,
    output logic [2:0] dbg_state
);

    localparam int CW = $clog2(DATA_NUM + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR1    = 3'd1,
        PAYLOAD = 3'd2,
        TAIL    = 3'd3,
        DRAIN   = 3'd4
    } state_t;

    state_t        state;
    logic          cs_meta;
    logic          cs_sync;
    logic          cs_prev;
    logic          cs_fall;
    logic          cs_rise;
    logic [5:0]    seq;
    logic          last_grant;
    logic          pending;
    logic [CW-1:0] cnt;
    logic [1:0]    grant;
    logic [7:0]    grant_dout;
    logic          cnt_last;
    logic          cnt_full;

    assign dbg_state = state;
    assign cs_fall   = cs_prev & ~cs_sync;
    assign cs_rise   = ~cs_prev & cs_sync;
    assign cnt_last  = (cnt == CW'(DATA_NUM - 1));
    assign cnt_full  = (cnt == CW'(DATA_NUM));

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            cs_meta <= 1'b1;
            cs_sync <= 1'b1;
            cs_prev <= 1'b1;
        end else begin
            cs_meta <= spi_cs;
            cs_sync <= cs_meta;
            cs_prev <= cs_sync;
        end
    end

    // Round-robin between two ready channels; code 3 marks a null frame.
    always_comb begin
        grant = 2'd3;
        if (ch0_frame_rdy && ch1_frame_rdy) begin
            grant = last_grant ? 2'd0 : 2'd1;
        end else if (ch0_frame_rdy) begin
            grant = 2'd0;
        end else if (ch1_frame_rdy) begin
            grant = 2'd1;
        end
    end

    always_comb begin
        grant_dout = 8'h00;
        if (frame_ch == 2'd0) begin
            grant_dout = ch0_dout;
        end else if (frame_ch == 2'd1) begin
            grant_dout = ch1_dout;
        end
    end

    // byte_req is a one-cycle strobe: the slave has latched spi_data and the
    // next byte must be registered by the following edge; a coincident cs
    // rising edge wins and the strobe is dropped.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            spi_data    <= SYNC_BYTE;
            ch0_rd_en   <= 1'b0;
            ch1_rd_en   <= 1'b0;
            frame_busy  <= 1'b0;
            frame_ch    <= 2'd0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            seq         <= 6'd0;
            last_grant  <= 1'b1;
            pending     <= 1'b0;
            cnt         <= '0;
        end else begin
            ch0_rd_en   <= 1'b0;
            ch1_rd_en   <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            case (state)
                IDLE: begin
                    spi_data <= SYNC_BYTE;
                    if (cs_fall || pending) begin
                        pending    <= 1'b0;
                        frame_ch   <= grant;
                        cnt        <= '0;
                        frame_busy <= 1'b1;
                        state      <= HDR1;
                    end
                end
                HDR1, PAYLOAD: begin
                    if (cs_rise) begin
                        frame_abort <= 1'b1;
                        seq         <= seq + 6'd1;
                        if (frame_ch == 2'd3) begin
                            spi_data   <= SYNC_BYTE;
                            frame_busy <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            spi_data <= 8'h00;
                            state    <= DRAIN;
                        end
                    end else if (byte_req) begin
                        if (state == HDR1) begin
                            spi_data <= {seq, frame_ch};
                            state    <= PAYLOAD;
                        end else begin
                            spi_data  <= grant_dout;
                            ch0_rd_en <= (frame_ch == 2'd0);
                            ch1_rd_en <= (frame_ch == 2'd1);
                            cnt       <= cnt + 1'b1;
                            if (cnt_last) begin
                                state <= TAIL;
                            end
                        end
                    end
                end
                TAIL: begin
                    spi_data <= 8'h00;
                    if (cs_rise) begin
                        frame_done <= 1'b1;
                        seq        <= seq + 6'd1;
                        if (frame_ch != 2'd3) begin
                            last_grant <= frame_ch[0];
                        end
                        spi_data   <= SYNC_BYTE;
                        frame_busy <= 1'b0;
                        state      <= IDLE;
                    end
                end
                DRAIN: begin
                    spi_data <= 8'h00;
                    if (cs_fall) begin
                        pending <= 1'b1;
                    end
                    // Popping the rest of the frame keeps the FIFO frame-aligned.
                    if (cnt_full) begin
                        last_grant <= frame_ch[0];
                        spi_data   <= SYNC_BYTE;
                        frame_busy <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        ch0_rd_en <= (frame_ch == 2'd0);
                        ch1_rd_en <= (frame_ch == 2'd1);
                        cnt       <= cnt + 1'b1;
                    end
                end
                default: begin
                    spi_data   <= SYNC_BYTE;
                    frame_busy <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_sched.sv
// Directed bench for spi_frame_sched: a frame table plus hand-written abort,
// drain-pending and mid-frame reset sequences against pointer-based FIFO models.
module tb_spi_frame_sched;

    localparam int DATA_NUM = 800;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       spi_cs;
    logic       byte_req;
    logic [7:0] spi_data;
    logic       ch0_frame_rdy;
    logic       ch1_frame_rdy;
    logic [7:0] ch0_dout;
    logic [7:0] ch1_dout;
    logic       ch0_rd_en;
    logic       ch1_rd_en;
    logic       frame_busy;
    logic [1:0] frame_ch;
    logic       frame_done;
    logic       frame_abort;
    logic [2:0] dbg_state;

    int total = 0;
    int bad = 0;
    int ptr0 = 0;
    int ptr1 = 0;
    int base_ptr[2];
    logic [7:0] exp_q[$];

    spi_frame_sched dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .spi_cs       (spi_cs),
        .byte_req     (byte_req),
        .spi_data     (spi_data),
        .ch0_frame_rdy(ch0_frame_rdy),
        .ch1_frame_rdy(ch1_frame_rdy),
        .ch0_dout     (ch0_dout),
        .ch1_dout     (ch1_dout),
        .ch0_rd_en    (ch0_rd_en),
        .ch1_rd_en    (ch1_rd_en),
        .frame_busy   (frame_busy),
        .frame_ch     (frame_ch),
        .frame_done   (frame_done),
        .frame_abort  (frame_abort),
        .dbg_state    (dbg_state)
    );

    // clock / reset / FIFO models
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        if (ch0_rd_en) ptr0 <= ptr0 + 1;
        if (ch1_rd_en) ptr1 <= ptr1 + 1;
    end

    assign ch0_dout = 8'(ptr0);
    assign ch1_dout = 8'(ptr1) ^ 8'h3C;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] model_byte(input logic [1:0] ch, input int p);
        logic [7:0] b;
        b = 8'(p);
        return (ch == 2'd1) ? (b ^ 8'h3C) : b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic pulse_req();
        @(negedge sys_clk);
        byte_req = 1'b1;
        @(negedge sys_clk);
        byte_req = 1'b0;
    endtask

    // driver tasks
    task automatic start_frame(input logic r0, input logic r1, input logic [1:0] exp_ch);
        logic seen;
        seen = 1'b0;
        ch0_frame_rdy = r0;
        ch1_frame_rdy = r1;
        check("idle_data", spi_data, 8'hA5);
        spi_cs = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            if (frame_busy) begin
                seen = 1'b1;
                break;
            end
        end
        check("start_busy", seen, 1);
        check("grant", frame_ch, exp_ch);
        ch0_frame_rdy = 1'b0;
        ch1_frame_rdy = 1'b0;
        tick(2);
    endtask

    task automatic send_bytes(input logic [1:0] ch, input logic [5:0] sq, input int npay);
        logic [7:0] e;
        logic [1:0] exp_rd;
        exp_rd = (ch == 2'd0) ? 2'b01 : (ch == 2'd1) ? 2'b10 : 2'b00;
        pulse_req();
        check("hdr1", spi_data, {sq, ch});
        check("hdr_rd", {ch1_rd_en, ch0_rd_en}, 0);
        tick(2);
        for (int k = 0; k < npay; k++) begin
            exp_q.push_back((ch == 2'd3) ? 8'h00 : model_byte(ch, base_ptr[ch[0]] + k));
        end
        for (int k = 0; k < npay; k++) begin
            pulse_req();
            e = exp_q.pop_front();
            check("payload", spi_data, e);
            check("pop", {ch1_rd_en, ch0_rd_en}, exp_rd);
            tick(2);
        end
        if (ch != 2'd3) base_ptr[ch[0]] += npay;
    endtask

    task automatic end_frame();
        logic seen_done;
        logic seen_abort;
        seen_done = 1'b0;
        seen_abort = 1'b0;
        pulse_req();
        check("tail_data", spi_data, 8'h00);
        check("tail_rd", {ch1_rd_en, ch0_rd_en}, 0);
        check("tail_state", dbg_state, 3);
        spi_cs = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            if (frame_abort) seen_abort = 1'b1;
            if (frame_done) begin
                seen_done = 1'b1;
                break;
            end
        end
        check("done_pulse", seen_done, 1);
        check("no_abort", seen_abort, 0);
        tick(1);
        check("done_busy", frame_busy, 0);
        check("done_data", spi_data, 8'hA5);
        tick(2);
    endtask

    task automatic wait_abort();
        logic seen;
        seen = 1'b0;
        spi_cs = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            if (frame_abort) begin
                seen = 1'b1;
                break;
            end
        end
        check("abort_pulse", seen, 1);
    endtask

    typedef struct {
        logic       r0;
        logic       r1;
        logic [1:0] ch;
        logic [5:0] sq;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int n0, n1, first, last, s0, s1;
        logic seen;

        vecs[0] = '{1'b1, 1'b1, 2'd0, 6'd0};
        vecs[1] = '{1'b1, 1'b1, 2'd1, 6'd1};
        vecs[2] = '{1'b1, 1'b1, 2'd0, 6'd2};
        vecs[3] = '{1'b0, 1'b0, 2'd3, 6'd3};
        vecs[4] = '{1'b1, 1'b1, 2'd1, 6'd4};
        vecs[5] = '{1'b1, 1'b0, 2'd0, 6'd5};
        vecs[6] = '{1'b0, 1'b1, 2'd1, 6'd6};
        base_ptr[0] = 0;
        base_ptr[1] = 0;

        sys_rst_n = 1'b0;
        spi_cs = 1'b1;
        byte_req = 1'b0;
        ch0_frame_rdy = 1'b0;
        ch1_frame_rdy = 1'b0;
        tick(3);
        check("rst_data", spi_data, 8'hA5);
        check("rst_rd", {ch1_rd_en, ch0_rd_en}, 0);
        check("rst_busy", frame_busy, 0);
        check("rst_ch", frame_ch, 0);
        check("rst_pulses", {frame_done, frame_abort}, 0);
        check("rst_state", dbg_state, 0);
        sys_rst_n = 1'b1;
        tick(2);

        // full frames: grant rotation, null frame, header sequence numbers
        for (int i = 0; i < 7; i++) begin
            start_frame(vecs[i].r0, vecs[i].r1, vecs[i].ch);
            send_bytes(vecs[i].ch, vecs[i].sq, DATA_NUM);
            end_frame();
        end

        // ch1 abort after 100 payload bytes, then drain of the remaining 700
        start_frame(1'b0, 1'b1, 2'd1);
        send_bytes(2'd1, 6'd7, 100);
        wait_abort();
        n0 = 0; n1 = 0; first = -1; last = -1;
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge sys_clk);
            if (ch0_rd_en) n0++;
            if (ch1_rd_en) begin
                n1++;
                if (first < 0) first = i;
                last = i;
            end
            if (!frame_busy) begin
                seen = 1'b1;
                break;
            end
        end
        check("drain_end", seen, 1);
        check("drain_pops", n1, 700);
        check("drain_contig", last - first + 1, 700);
        check("drain_rd0", n0, 0);
        check("drain_idle", dbg_state, 0);
        base_ptr[1] += 700;
        tick(2);
        start_frame(1'b0, 1'b1, 2'd1);
        send_bytes(2'd1, 6'd8, DATA_NUM);
        end_frame();

        // null-frame abort goes straight back to idle without pops
        s0 = ptr0; s1 = ptr1;
        start_frame(1'b0, 1'b0, 2'd3);
        send_bytes(2'd3, 6'd9, 3);
        wait_abort();
        tick(2);
        check("null_abort_idle", dbg_state, 0);
        check("null_abort_pops", (ptr0 - s0) + (ptr1 - s1), 0);

        // cs falls again during drain: the next frame starts on its own
        start_frame(1'b1, 1'b0, 2'd0);
        send_bytes(2'd0, 6'd10, 10);
        wait_abort();
        tick(4);
        check("drain_state", dbg_state, 4);
        spi_cs = 1'b0;
        ch0_frame_rdy = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge sys_clk);
            if (!frame_busy) begin
                seen = 1'b1;
                break;
            end
        end
        check("pend_drain_end", seen, 1);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk);
            if (frame_busy) begin
                seen = 1'b1;
                break;
            end
        end
        check("pend_restart", seen, 1);
        check("pend_grant", frame_ch, 0);
        ch0_frame_rdy = 1'b0;
        base_ptr[0] += 790;
        tick(2);
        send_bytes(2'd0, 6'd11, DATA_NUM);
        end_frame();

        // reset in the middle of a payload abandons the frame quietly
        start_frame(1'b1, 1'b0, 2'd0);
        send_bytes(2'd0, 6'd12, 5);
        sys_rst_n = 1'b0;
        spi_cs = 1'b1;
        s0 = ptr0;
        tick(1);
        check("mid_rst_data", spi_data, 8'hA5);
        check("mid_rst_rd", {ch1_rd_en, ch0_rd_en}, 0);
        check("mid_rst_busy", frame_busy, 0);
        check("mid_rst_ch", frame_ch, 0);
        check("mid_rst_pulses", {frame_done, frame_abort}, 0);
        check("mid_rst_state", dbg_state, 0);
        tick(3);
        sys_rst_n = 1'b1;
        tick(5);
        check("mid_rst_pops", ptr0 - s0, 0);
        start_frame(1'b1, 1'b1, 2'd0);
        send_bytes(2'd0, 6'd0, DATA_NUM);
        end_frame();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
